// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the pipelined MIPS control unit:
// opcode and ALU-op encodings plus the per-instruction control bundle.
package mips_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] ALU_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] ALU_SUB = 6'b100010;

    typedef struct packed {
        logic               RegDst;
        logic               ALUSrc;
        logic [FUNCT_W-1:0] ALUOp;
        logic               Branch;
        logic               MemRead;
        logic               MemWrite;
        logic               MemtoReg;
        logic               RegWrite;
    } ctrl_bundle_t;

    // A bubble carries no side effects in any later stage.
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Datapath <-> control-unit signal bundle. The datapath side uses the
// master modport, the control unit the slave modport.
// Optional macro PERF_CNT_EN adds the performance counter outputs.
interface pipelined_control_unit_if #(
    parameter int INSTR_W    = 32,
    parameter int ALUOP_W    = 6,
    parameter int REG_ADDR_W = 5
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
);
    logic [INSTR_W-1:0]    ID_Instr;
    logic                  ID_Valid;
    logic                  ALUZero;
    logic                  EX_RegDst;
    logic                  EX_ALUSrc;
    logic [ALUOP_W-1:0]    EX_ALUOp;
    logic                  MEM_MemRead;
    logic                  MEM_MemWrite;
    logic                  WB_MemtoReg;
    logic                  WB_RegWrite;
    logic [REG_ADDR_W-1:0] WB_WriteReg;
    logic                  PCSrc;
    logic                  Stall;
    logic                  Flush;
    logic                  IllegalInstr;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0]      StallCnt;
    logic [CNT_W-1:0]      FlushCnt;
    logic [CNT_W-1:0]      IllegalCnt;
`endif

    modport master (
        output ID_Instr, ID_Valid, ALUZero,
        input  EX_RegDst, EX_ALUSrc, EX_ALUOp, MEM_MemRead, MEM_MemWrite,
               WB_MemtoReg, WB_RegWrite, WB_WriteReg, PCSrc, Stall, Flush,
               IllegalInstr
`ifdef PERF_CNT_EN
        , input StallCnt, FlushCnt, IllegalCnt
`endif
    );

    modport slave (
        input  ID_Instr, ID_Valid, ALUZero,
        output EX_RegDst, EX_ALUSrc, EX_ALUOp, MEM_MemRead, MEM_MemWrite,
               WB_MemtoReg, WB_RegWrite, WB_WriteReg, PCSrc, Stall, Flush,
               IllegalInstr
`ifdef PERF_CNT_EN
        , output StallCnt, FlushCnt, IllegalCnt
`endif
    );

endinterface

// File: rtl/pipelined_control_unit_main_decoder.sv
// Purely combinational main decoder: opcode/funct -> control bundle plus
// an illegal-opcode flag. Invalid slots decode to a bubble.
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                is_nop,
    input  logic                valid,
    output ctrl_bundle_t        ctrl,
    output logic                illegal
);

    // Opcode table; anything not listed is a zero bundle flagged illegal.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        if (valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.RegDst   = 1'b1;
                    ctrl.ALUOp    = funct;
                    ctrl.RegWrite = ~is_nop;
                end
                OP_LW: begin
                    ctrl.ALUSrc   = 1'b1;
                    ctrl.ALUOp    = ALU_ADD;
                    ctrl.MemRead  = 1'b1;
                    ctrl.MemtoReg = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                OP_SW: begin
                    ctrl.ALUSrc   = 1'b1;
                    ctrl.ALUOp    = ALU_ADD;
                    ctrl.MemWrite = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.ALUOp    = ALU_SUB;
                    ctrl.Branch   = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.ALUSrc   = 1'b1;
                    ctrl.ALUOp    = ALU_ADD;
                    ctrl.RegWrite = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: decodes the IF/ID instruction, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, and resolves load-use
// stalls and taken-branch flushes.
// Optional macro PERF_CNT_EN adds saturating stall/flush/illegal counters.
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ALUOP_W    = 6,
    parameter int REG_ADDR_W = 5
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input logic                     Clk,
    input logic                     Rst,
    pipelined_control_unit_if.slave bus
);

    typedef struct packed {
        logic                  MemRead;
        logic                  MemWrite;
        logic                  MemtoReg;
        logic                  RegWrite;
        logic [REG_ADDR_W-1:0] WriteReg;
    } mem_stage_t;

    typedef struct packed {
        logic                  MemtoReg;
        logic                  RegWrite;
        logic [REG_ADDR_W-1:0] WriteReg;
    } wb_stage_t;

    logic [OPCODE_W-1:0]   id_opcode;
    logic [FUNCT_W-1:0]    id_funct;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_is_nop;
    logic                  id_uses_rt;

    ctrl_bundle_t          dec_ctrl;
    logic                  dec_illegal;

    ctrl_bundle_t          ex_ctrl_q, ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  illegal_q, illegal_d;
    mem_stage_t            mem_q, mem_d;
    wb_stage_t             wb_q, wb_d;

    logic                  pcsrc;
    logic                  load_use;
    logic                  stall;
    logic                  bubble;
    logic [REG_ADDR_W-1:0] ex_write_reg;

    assign id_opcode  = bus.ID_Instr[INSTR_W-1 -: OPCODE_W];
    assign id_funct   = bus.ID_Instr[FUNCT_W-1:0];
    assign id_rs      = bus.ID_Instr[21 +: REG_ADDR_W];
    assign id_rt      = bus.ID_Instr[16 +: REG_ADDR_W];
    assign id_rd      = bus.ID_Instr[11 +: REG_ADDR_W];
    assign id_is_nop  = (bus.ID_Instr == '0);
    // Only these formats read rt as a source; lw/addi write it instead.
    assign id_uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
                        (id_opcode == OP_BEQ);

    main_decoder u_main_decoder (
        .opcode  (id_opcode),
        .funct   (id_funct),
        .is_nop  (id_is_nop),
        .valid   (bus.ID_Valid),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Hazard resolution: a taken branch wins over a load-use stall.
    always_comb begin
        pcsrc    = ex_ctrl_q.Branch & bus.ALUZero;
        load_use = ex_ctrl_q.MemRead && (ex_rt_q != '0) && bus.ID_Valid &&
                   ((ex_rt_q == id_rs) || (id_uses_rt && (ex_rt_q == id_rt)));
        stall    = load_use & ~pcsrc;
        bubble   = stall | pcsrc;
    end

    // Next-state for every stage register; stall or flush inject a bubble into ID/EX.
    always_comb begin
        ex_write_reg = ex_ctrl_q.RegDst ? ex_rd_q : ex_rt_q;

        // ID -> EX
        ex_ctrl_d = dec_ctrl;
        ex_rt_d   = id_rt;
        ex_rd_d   = id_rd;
        illegal_d = dec_illegal;
        if (bubble) begin
            ex_ctrl_d = CTRL_BUBBLE;
            ex_rt_d   = '0;
            ex_rd_d   = '0;
            illegal_d = 1'b0;
        end

        // EX -> MEM
        mem_d.MemRead  = ex_ctrl_q.MemRead;
        mem_d.MemWrite = ex_ctrl_q.MemWrite;
        mem_d.MemtoReg = ex_ctrl_q.MemtoReg;
        mem_d.RegWrite = ex_ctrl_q.RegWrite;
        mem_d.WriteReg = ex_write_reg;

        // MEM -> WB
        wb_d.MemtoReg  = mem_q.MemtoReg;
        wb_d.RegWrite  = mem_q.RegWrite;
        wb_d.WriteReg  = mem_q.WriteReg;
    end

    // Stage registers advance every cycle; reset discards everything in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex_ctrl_q <= CTRL_BUBBLE;
            ex_rt_q   <= '0;
            ex_rd_q   <= '0;
            illegal_q <= 1'b0;
            mem_q     <= '0;
            wb_q      <= '0;
        end else begin
            ex_ctrl_q <= ex_ctrl_d;
            ex_rt_q   <= ex_rt_d;
            ex_rd_q   <= ex_rd_d;
            illegal_q <= illegal_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
        end
    end

    assign bus.EX_RegDst    = ex_ctrl_q.RegDst;
    assign bus.EX_ALUSrc    = ex_ctrl_q.ALUSrc;
    assign bus.EX_ALUOp     = ALUOP_W'(ex_ctrl_q.ALUOp);
    assign bus.MEM_MemRead  = mem_q.MemRead;
    assign bus.MEM_MemWrite = mem_q.MemWrite;
    assign bus.WB_MemtoReg  = wb_q.MemtoReg;
    assign bus.WB_RegWrite  = wb_q.RegWrite;
    assign bus.WB_WriteReg  = wb_q.WriteReg;
    assign bus.PCSrc        = pcsrc;
    assign bus.Flush        = pcsrc;
    assign bus.Stall        = stall;
    assign bus.IllegalInstr = illegal_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic ev);
        return (ev && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Event counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d   = sat_inc(stall_cnt_q, stall);
        flush_cnt_d   = sat_inc(flush_cnt_q, pcsrc);
        illegal_cnt_d = sat_inc(illegal_cnt_q, illegal_q);
    end

    // Counter state, cleared together with the pipeline.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.StallCnt   = stall_cnt_q;
    assign bus.FlushCnt   = flush_cnt_q;
    assign bus.IllegalCnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: reset, decode/latency,
// load-use stall, branch flush, flush-over-stall and illegal opcodes.
module tb_pipelined_control_unit;

    localparam logic [31:0] I_NOP       = 32'h0000_0000;
    localparam logic [31:0] I_ADD3      = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_LW2       = 32'h8C22_0000; // lw   $2,0($1)
    localparam logic [31:0] I_ADD_DEP   = 32'h0045_2020; // add  $4,$2,$5
    localparam logic [31:0] I_ADD_INDEP = 32'h00C5_2020; // add  $4,$6,$5
    localparam logic [31:0] I_BEQ       = 32'h1022_0004; // beq  $1,$2,4
    localparam logic [31:0] I_SW        = 32'hAC22_0004; // sw   $2,4($1)
    localparam logic [31:0] I_ADDI5     = 32'h2025_0007; // addi $5,$1,7
    localparam logic [31:0] I_ILL       = 32'hFC00_0000; // opcode 111111

    logic Clk = 1'b0;
    logic Rst;
    int   n_cmp = 0;
    int   n_err = 0;

    pipelined_control_unit_if bus_if ();

    pipelined_control_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic v);
        bus_if.ID_Instr = instr;
        bus_if.ID_Valid = v;
        #1;
    endtask

    initial begin
        Rst             = 1'b0;
        bus_if.ID_Instr = '0;
        bus_if.ID_Valid = 1'b0;
        bus_if.ALUZero  = 1'b0;
        #2;
        check("rst_ex_aluop",   32'(bus_if.EX_ALUOp), 0);
        check("rst_ex_regdst",  32'(bus_if.EX_RegDst), 0);
        check("rst_mem_read",   32'(bus_if.MEM_MemRead), 0);
        check("rst_wb_regwr",   32'(bus_if.WB_RegWrite), 0);
        check("rst_wb_wreg",    32'(bus_if.WB_WriteReg), 0);
        check("rst_illegal",    32'(bus_if.IllegalInstr), 0);
        check("rst_stall",      32'(bus_if.Stall), 0);
        check("rst_pcsrc",      32'(bus_if.PCSrc), 0);
        @(negedge Clk);
        Rst = 1'b1;

        // add $3,$1,$2: EX after 1 edge, WB after 3
        tick();
        issue(I_ADD3, 1'b1);
        check("add_no_stall", 32'(bus_if.Stall), 0);
        tick();
        check("add_ex_aluop",  32'(bus_if.EX_ALUOp), 32'h20);
        check("add_ex_regdst", 32'(bus_if.EX_RegDst), 1);
        check("add_ex_alusrc", 32'(bus_if.EX_ALUSrc), 0);
        issue(I_NOP, 1'b1);
        tick();
        check("add_mem_read",  32'(bus_if.MEM_MemRead), 0);
        check("add_wb_early",  32'(bus_if.WB_RegWrite), 0);
        tick();
        check("add_wb_regwr",  32'(bus_if.WB_RegWrite), 1);
        check("add_wb_wreg",   32'(bus_if.WB_WriteReg), 3);
        check("add_wb_m2r",    32'(bus_if.WB_MemtoReg), 0);
        tick();
        check("nop_wb_regwr",  32'(bus_if.WB_RegWrite), 0);

        // lw $2 followed by dependent add: one stall cycle
        issue(I_LW2, 1'b1);
        tick();
        check("lw_ex_alusrc",  32'(bus_if.EX_ALUSrc), 1);
        check("lw_ex_aluop",   32'(bus_if.EX_ALUOp), 32'h20);
        issue(I_ADD_DEP, 1'b1);
        check("lu_stall",      32'(bus_if.Stall), 1);
        check("lu_no_flush",   32'(bus_if.Flush), 0);
        tick();
        check("lu_ex_bubble",  32'(bus_if.EX_ALUOp), 0);
        check("lu_ex_rd0",     32'(bus_if.EX_RegDst), 0);
        check("lu_mem_read",   32'(bus_if.MEM_MemRead), 1);
        check("lu_stall_once", 32'(bus_if.Stall), 0);
        tick();
        check("lu_ex_add",     32'(bus_if.EX_RegDst), 1);
        check("lu_ex_add_op",  32'(bus_if.EX_ALUOp), 32'h20);
        check("lw_wb_regwr",   32'(bus_if.WB_RegWrite), 1);
        check("lw_wb_m2r",     32'(bus_if.WB_MemtoReg), 1);
        check("lw_wb_wreg",    32'(bus_if.WB_WriteReg), 2);
        issue(I_NOP, 1'b1);
        tick();

        // lw followed by independent add: no stall
        issue(I_LW2, 1'b1);
        tick();
        issue(I_ADD_INDEP, 1'b1);
        check("indep_no_stall", 32'(bus_if.Stall), 0);
        tick();
        check("indep_ex_add",  32'(bus_if.EX_RegDst), 1);

        // sw then addi $5
        issue(I_SW, 1'b1);
        tick();
        check("sw_ex_alusrc",  32'(bus_if.EX_ALUSrc), 1);
        issue(I_ADDI5, 1'b1);
        check("sw_no_stall",   32'(bus_if.Stall), 0);
        tick();
        check("sw_mem_write",  32'(bus_if.MEM_MemWrite), 1);
        check("addi_ex_regdst", 32'(bus_if.EX_RegDst), 0);
        issue(I_NOP, 1'b1);
        tick();
        check("sw_wb_regwr",   32'(bus_if.WB_RegWrite), 0);
        check("addi_mem_wr",   32'(bus_if.MEM_MemWrite), 0);
        tick();
        check("addi_wb_regwr", 32'(bus_if.WB_RegWrite), 1);
        check("addi_wb_wreg",  32'(bus_if.WB_WriteReg), 5);

        // beq taken: flush the follower
        issue(I_BEQ, 1'b1);
        tick();
        bus_if.ALUZero = 1'b1;
        issue(I_ADD3, 1'b1);
        check("bt_pcsrc",      32'(bus_if.PCSrc), 1);
        check("bt_flush",      32'(bus_if.Flush), 1);
        check("bt_no_stall",   32'(bus_if.Stall), 0);
        tick();
        bus_if.ALUZero = 1'b0;
        issue(I_NOP, 1'b1);
        check("bt_ex_bubble",  32'(bus_if.EX_ALUOp), 0);
        check("bt_ex_rd0",     32'(bus_if.EX_RegDst), 0);
        check("bt_flush_once", 32'(bus_if.Flush), 0);
        tick();
        check("bt_mem_read",   32'(bus_if.MEM_MemRead), 0);
        check("bt_mem_write",  32'(bus_if.MEM_MemWrite), 0);
        tick();
        check("bt_wb_regwr",   32'(bus_if.WB_RegWrite), 0);

        // beq not taken
        issue(I_BEQ, 1'b1);
        tick();
        issue(I_ADD3, 1'b1);
        check("bn_pcsrc",      32'(bus_if.PCSrc), 0);
        check("bn_flush",      32'(bus_if.Flush), 0);
        tick();
        check("bn_ex_add",     32'(bus_if.EX_RegDst), 1);
        check("bn_ex_op",      32'(bus_if.EX_ALUOp), 32'h20);
        issue(I_NOP, 1'b1);
        tick();

        // beq stalled behind lw, then taken: flush wins, no stall
        issue(I_LW2, 1'b1);
        tick();
        issue(I_BEQ, 1'b1);
        check("fs_beq_stall",  32'(bus_if.Stall), 1);
        tick();
        check("fs_stall_once", 32'(bus_if.Stall), 0);
        tick();
        check("fs_ex_beq",     32'(bus_if.EX_ALUOp), 32'h22);
        bus_if.ALUZero = 1'b1;
        issue(I_ADD_DEP, 1'b1);
        check("fs_flush",      32'(bus_if.Flush), 1);
        check("fs_stall0",     32'(bus_if.Stall), 0);
        tick();
        bus_if.ALUZero = 1'b0;
        issue(I_NOP, 1'b1);
        check("fs_ex_bubble",  32'(bus_if.EX_ALUOp), 0);

        // illegal opcode, valid then invalid
        issue(I_ILL, 1'b1);
        check("ill_no_stall",  32'(bus_if.Stall), 0);
        tick();
        check("ill_flag",      32'(bus_if.IllegalInstr), 1);
        check("ill_ex_aluop",  32'(bus_if.EX_ALUOp), 0);
        check("ill_ex_regdst", 32'(bus_if.EX_RegDst), 0);
        check("ill_ex_alusrc", 32'(bus_if.EX_ALUSrc), 0);
        issue(I_ILL, 1'b0);
        tick();
        check("ill_inv_flag",  32'(bus_if.IllegalInstr), 0);
        check("ill_inv_rd",    32'(bus_if.EX_RegDst), 0);
        issue(I_NOP, 1'b1);
        tick();
        check("ill_flag_once", 32'(bus_if.IllegalInstr), 0);
`ifdef PERF_CNT_EN
        check("cnt_illegal",   32'(bus_if.IllegalCnt), 1);
        check("cnt_stall",     32'(bus_if.StallCnt), 2);
        check("cnt_flush",     32'(bus_if.FlushCnt), 2);
`endif

        // async reset with lw in MEM
        issue(I_LW2, 1'b1);
        tick();
        issue(I_NOP, 1'b1);
        tick();
        check("mr_mem_read_pre", 32'(bus_if.MEM_MemRead), 1);
        #1;
        Rst = 1'b0;
        #1;
        check("mr_mem_read",   32'(bus_if.MEM_MemRead), 0);
        check("mr_ex_regdst",  32'(bus_if.EX_RegDst), 0);
        check("mr_ex_aluop",   32'(bus_if.EX_ALUOp), 0);
        check("mr_wb_regwr",   32'(bus_if.WB_RegWrite), 0);
`ifdef PERF_CNT_EN
        check("mr_cnt_illegal", 32'(bus_if.IllegalCnt), 0);
`endif
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        check("mr_wb_m2r",     32'(bus_if.WB_MemtoReg), 0);
        check("mr_wb_regwr1",  32'(bus_if.WB_RegWrite), 0);
        tick();
        check("mr_mem_read2",  32'(bus_if.MEM_MemRead), 0);
        tick();
        check("mr_wb_regwr3",  32'(bus_if.WB_RegWrite), 0);
        check("mr_wb_wreg3",   32'(bus_if.WB_WriteReg), 0);
        check("mr_illegal",    32'(bus_if.IllegalInstr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
